// File: rtl/packet_arbiter.sv
// Multi-input packet arbiter with a one-entry output register; round-robin by default,
// fixed lowest-index priority when PACKET_ARBITER_FIXED_PRIO_EN is defined.
module packet_arbiter #(
  parameter  int p_nbits   = 8,
  parameter  int p_ninputs = 4,
  localparam int S         = $clog2(p_ninputs),
  localparam int W         = p_nbits + S
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_ninputs-1:0]         recv_val,
  output logic [p_ninputs-1:0]         recv_rdy,
  input  logic [p_ninputs*p_nbits-1:0] recv_msg,
  output logic                         send_val,
  input  logic                         send_rdy,
  output logic [W-1:0]                 send_msg
);

  logic                 r_send_val;
  logic [W-1:0]         r_send_msg;
  logic                 w_can, w_any, w_xfer;
  logic [S-1:0]         w_grant;
  logic [p_nbits-1:0]   w_payload;
  logic [p_ninputs-1:0] w_onehot;

`ifdef PACKET_ARBITER_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    for (int i = p_ninputs-1; i >= 0; i--)
      if (recv_val[i]) w_grant = S'(i);
  end
`else
  logic [S-1:0]         r_ptr;
  logic [p_ninputs-1:0] w_hi;

  // Prefer the lowest valid at or above ptr; otherwise wrap to the lowest valid overall.
  always_comb begin
    w_hi    = '0;
    w_grant = '0;
    for (int i = 0; i < p_ninputs; i++)
      w_hi[i] = recv_val[i] && (i >= int'(r_ptr));
    for (int i = p_ninputs-1; i >= 0; i--)
      if (recv_val[i]) w_grant = S'(i);
    if (|w_hi)
      for (int i = p_ninputs-1; i >= 0; i--)
        if (w_hi[i]) w_grant = S'(i);
  end

  // Explicit wrap keeps ptr legal when p_ninputs is not a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_ptr <= '0;
    else if (w_xfer) r_ptr <= (w_grant == S'(p_ninputs-1)) ? '0 : w_grant + S'(1);
  end
`endif

  always_comb begin
    w_onehot  = '0;
    w_payload = '0;
    for (int i = 0; i < p_ninputs; i++) begin
      w_onehot[i] = (int'(w_grant) == i);
      if (int'(w_grant) == i) w_payload = recv_msg[i*p_nbits +: p_nbits];
    end
  end

  assign w_any    = |recv_val;
  assign w_can    = !r_send_val || send_rdy;
  assign w_xfer   = reset && w_can && w_any;
  assign recv_rdy = w_xfer ? w_onehot : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_send_val <= 1'b0;
      r_send_msg <= '0;
    end else if (w_xfer) begin
      r_send_val <= 1'b1;
      r_send_msg <= {w_grant, w_payload};
    end else if (send_rdy) begin
      r_send_val <= 1'b0;
    end
  end

  assign send_val = r_send_val;
  assign send_msg = r_send_msg;

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 SHALL have parameter p_nbits, default 8: payload width per input; legal range >= 1.
REQ-002 SHALL have parameter p_ninputs, default 4: number of input streams; legal range >= 2, powers of two not required.
REQ-003 SHALL define local width S = $clog2(p_ninputs) and output width W = p_nbits + S.
REQ-004 SHALL have port clk  input  1: sole clock, rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset; asserted when 0.
REQ-006 SHALL have port recv_val  input  p_ninputs: per-input valid; bit i belongs to input i.
REQ-007 SHALL have port recv_rdy  output  p_ninputs: per-input ready, at most one bit high per cycle.
REQ-008 SHALL have port recv_msg  input  p_ninputs*p_nbits: input i payload occupies bits [i*p_nbits +: p_nbits].
REQ-009 SHALL have port send_val  output  1: output register holds a packet.
REQ-010 SHALL have port send_rdy  input  1: downstream (router) accepts this cycle.
REQ-011 SHALL have port send_msg  output  W: {source index (S bits, MSBs), payload}; routing field in MSBs, matching downstream router select extraction.

Function
REQ-012 SHALL transfer on an input i when recv_val[i] & recv_rdy[i] at a rising edge, and on the output when send_val & send_rdy.
REQ-013 SHALL hold a one-entry output register; can_accept = !send_val | send_rdy (accept while draining, same cycle).
REQ-014 SHALL compute grant combinationally: the first i with recv_val[i]=1, searching from priority pointer ptr upward and wrapping from p_ninputs-1 to 0.
REQ-015 SHALL drive recv_rdy = one-hot(grant) when can_accept and any recv_val is high, else all zero; recv_rdy SHALL NOT depend on recv_msg.
REQ-016 SHALL, on an input transfer from i, load send_msg = {i[S-1:0], payload_i} and set send_val=1 at that edge (latency 1 cycle, full throughput 1 packet/cycle).
REQ-017 SHALL clear send_val at an edge where the output transfers and no input transfers.
REQ-018 SHALL hold send_msg and send_val stable while send_val=1 and send_rdy=0.
REQ-019 SHALL update ptr to (grant+1) mod p_ninputs after every input transfer; ptr SHALL be unchanged otherwise.
REQ-020 SHALL keep ptr in range 0..p_ninputs-1 for non-power-of-two p_ninputs (explicit wrap, no modulo-2^S wrap).
REQ-021 SHALL ignore recv_msg of non-granted inputs; no input is dropped or duplicated.

Reset
REQ-022 SHALL, while reset=0, asynchronously force send_val=0, send_msg=0, ptr=0; recv_rdy=0 during reset.
REQ-023 SHALL discard any packet held in the output register when reset asserts mid-operation.
REQ-024 SHALL begin arbitration at the first rising edge after reset deasserts, with input 0 highest priority.

Configuration
REQ-025 SHALL support macro PACKET_ARBITER_FIXED_PRIO_EN.
REQ-026 SHALL, with PACKET_ARBITER_FIXED_PRIO_EN defined, use fixed priority: lowest-index valid input wins, ptr logic omitted.
REQ-027 SHALL, without PACKET_ARBITER_FIXED_PRIO_EN, use round-robin per REQ-014/REQ-019.

Verification (p_nbits=8, p_ninputs=4, W=10)
REQ-028 SHALL verify reset: reset=0 with recv_val=4'b1111 -> send_val=0, send_msg=0, recv_rdy=0; after release, first grant is input 0.
REQ-029 SHALL verify single source: recv_val=4'b0100, input 2 msg 0xA5, send_rdy=1 -> recv_rdy=4'b0100; next cycle send_val=1, send_msg=10'h2A5.
REQ-030 SHALL verify round-robin: recv_val=4'b1111 held, send_rdy=1 -> granted sources 0,1,2,3,0 on consecutive cycles, one packet per cycle.
REQ-031 SHALL verify backpressure: output full, send_rdy=0 for 3 cycles -> send_msg unchanged, recv_rdy=4'b0000; send_rdy=1 -> drain and new accept same cycle.
REQ-032 SHALL verify reset mid-operation: send_val=1 holding 10'h1FF, reset pulsed low between edges -> send_val=0 immediately, packet never delivered, ptr=0.
REQ-033 SHALL verify macro build: PACKET_ARBITER_FIXED_PRIO_EN defined, recv_val=4'b1010 held -> input 1 granted every cycle, input 3 never.
